// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shift/rotate unit: op encoding, FSM states
// and the single-bit step function reused by any shifter variant.
package shifter_pkg;

  localparam int MAX_W = 64;
  localparam int IDX_W = 6;

  localparam logic [2:0] OP_SRL = 3'd0;
  localparam logic [2:0] OP_SLL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_reserved(input logic [2:0] op);
    return (op > OP_ROL);
  endfunction

  // Operates on a zero-extended MAX_W vector; msb marks the real operand's top bit.
  // Bits above msb in the result are don't-care and dropped by the caller.
  function automatic logic [MAX_W:0] step(input logic [2:0] op,
                                          input logic [MAX_W-1:0] y,
                                          input logic [IDX_W-1:0] msb);
    logic [MAX_W-1:0] y_next;
    logic             c;
    y_next = y;
    c      = 1'b0;
    case (op)
      OP_SRL: begin y_next = y >> 1'b1; c = y[0]; end
      OP_SLL: begin y_next = y << 1'b1; c = y[msb]; end
      OP_SRA: begin y_next = y >> 1'b1; y_next[msb] = y[msb]; c = y[0]; end
      OP_ROR: begin y_next = y >> 1'b1; y_next[msb] = y[0]; c = y[0]; end
      OP_ROL: begin y_next = y << 1'b1; y_next[0] = y[msb]; c = y[msb]; end
      default: begin y_next = y; c = 1'b0; end
    endcase
    return {c, y_next};
  endfunction

endpackage

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one bit position per clock, valid/ready on both sides.
// WIDTH is limited to shifter_pkg::MAX_W by the shared step function.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero
);

  state_e           state_r;
  logic [2:0]       op_r;
  logic [AMT_W-1:0] cnt_r;
  logic [WIDTH-1:0] y_r;
  logic             carry_r;
  logic             zero_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [MAX_W-1:0] y_ext_s;
  logic [MAX_W:0]   step_s;
  logic [WIDTH-1:0] y_next_s;
  logic             carry_next_s;

  // Widen the working register and evaluate one step of the latched op.
  always_comb begin
    y_ext_s              = '0;
    y_ext_s[WIDTH-1:0]   = y_r;
    step_s               = step(op_r, y_ext_s, IDX_W'(WIDTH - 1));
    y_next_s             = step_s[WIDTH-1:0];
    carry_next_s         = step_s[MAX_W];
  end

  if (WIDTH < MAX_W) begin : g_pad
    logic unused_hi_s;
    assign unused_hi_s = ^step_s[MAX_W-1:WIDTH];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      op_r        <= 3'd0;
      cnt_r       <= '0;
      y_r         <= '0;
      carry_r     <= 1'b0;
      zero_r      <= 1'b1;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            y_r        <= a;
            op_r       <= op;
            cnt_r      <= amt;
            carry_r    <= 1'b0;
            zero_r     <= (a == '0);
            in_ready_r <= 1'b0;
            if ((amt != '0) && !is_reserved(op)) begin
              state_r <= ST_SHIFT;
            end else begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_SHIFT: begin
          y_r     <= y_next_s;
          carry_r <= carry_next_s;
          zero_r  <= (y_next_s == '0);
          cnt_r   <= cnt_r - AMT_W'(1);
          if (cnt_r == AMT_W'(1)) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign y         = y_r;
  assign carry     = carry_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter (WIDTH=8) with hand-computed results.
module tb_seq_shifter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] amt;
  logic [7:0] a;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       carry;
  logic       zero;

  int n_vec;
  int n_err;

  seq_shifter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .amt       (amt),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .carry     (carry),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for out_valid; returns the number of edges waited.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Issue one request from idle, check latency and result, then take it.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [3:0] n,
                        input logic [7:0] av, input logic [7:0] ey, input logic ec,
                        input int elat);
    int lat;
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; amt = n; a = av;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'd0; amt = 4'd0; a = 8'h00;
    wait_valid(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_y"}, 64'(y), 64'(ey));
    chk({tag, "_c"}, 64'(carry), 64'(ec));
    chk({tag, "_z"}, 64'(zero), 64'(ey == 8'h00));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovclr"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; amt = 4'd0; a = 8'h00;
    #12;
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_z", 64'(zero), 64'd1);
    chk("rst_c", 64'(carry), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("srl1",   3'd0, 4'd1,  8'hB5, 8'h5A, 1'b1, 1);
    run_op("sra3",   3'd2, 4'd3,  8'h80, 8'hF0, 1'b0, 3);
    run_op("sra10",  3'd2, 4'd10, 8'h80, 8'hFF, 1'b1, 10);
    run_op("rol9",   3'd4, 4'd9,  8'h81, 8'h03, 1'b1, 9);
    run_op("ror8",   3'd3, 4'd8,  8'h01, 8'h01, 1'b0, 8);
    run_op("sll0",   3'd1, 4'd0,  8'h3C, 8'h3C, 1'b0, 0);
    run_op("rsv6",   3'd6, 4'd5,  8'h3C, 8'h3C, 1'b0, 0);
    run_op("sll4",   3'd1, 4'd4,  8'hF0, 8'h00, 1'b1, 4);
    run_op("srl9",   3'd0, 4'd9,  8'hFF, 8'h00, 1'b0, 9);

    // Back-pressure with a second request already waiting on the input.
    in_valid = 1'b1; op = 3'd1; amt = 4'd2; a = 8'h0F;
    @(posedge clk); #1;
    op = 3'd3; amt = 4'd1; a = 8'h02;
    wait_valid(lat);
    chk("bp_lat", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ov", 64'(out_valid), 64'd1);
      chk("bp_y", 64'(y), 64'h3C);
      chk("bp_c", 64'(carry), 64'd0);
      chk("bp_rdy", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_ovclr", 64'(out_valid), 64'd0);
    chk("bp_rdyback", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("q2_rdy", 64'(in_ready), 64'd0);
    wait_valid(lat);
    chk("q2_lat", 64'(lat), 64'd1);
    chk("q2_y", 64'(y), 64'h01);
    chk("q2_c", 64'(carry), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a shift.
    in_valid = 1'b1; op = 3'd1; amt = 4'd6; a = 8'h0B;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("mrst_ov", 64'(out_valid), 64'd0);
    chk("mrst_y", 64'(y), 64'd0);
    chk("mrst_z", 64'(zero), 64'd1);
    chk("mrst_rdy", 64'(in_ready), 64'd1);
    chk("mrst_c", 64'(carry), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 3'd1, 4'd2, 8'h0B, 8'h2C, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
